// File: rtl/suma_mult_wb_if.sv
// Wishbone B4 classic bus bundle between the management SoC initiator and the
// suma_mult responder. Signal names keep the responder-side direction suffixes.
interface suma_mult_wb_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/suma_mult_wb_slave.sv
// Wishbone register front-end for the suma_mult core: CTRL/N/STATUS/RESULT map,
// registered ack, start handshake FSM with timeout, result capture and level irq.
module suma_mult_wb_slave #(
    parameter logic [31:0] BASE_ADDR     = 32'h3000_0000,
    parameter int          START_TIMEOUT = 16
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    suma_mult_wb_if.slave       wbs,
    output logic                core_start_o,
    output logic [15:0]         core_n_o,
    input  logic [31:0]         core_x_i,
    input  logic                core_b_i,
    output logic                irq_o
);

    localparam int TW = $clog2(START_TIMEOUT + 1);
    localparam logic [TW-1:0] START_LAST = TW'(START_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_START   = 2'd1,
        ST_RUN     = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] start_cnt;
    logic          irq_en, done, timeout;
    logic [31:0]   result;
    logic [31:0]   rdata;
    logic          busy;

    logic          hit, wr, rd;
    logic [1:0]    reg_idx;
    logic          ctrl_wr, n_wr, status_wr;
    logic          start_req, timeout_evt, capture;
    logic          unused_bits;

    assign reg_idx   = wbs.wbs_adr_i[3:2];
    assign hit       = (wbs.wbs_adr_i[31:4] == BASE_ADDR[31:4]) && wbs.wbs_cyc_i
                       && wbs.wbs_stb_i && !wbs.wbs_ack_o;
    assign wr        = hit && wbs.wbs_we_i;
    assign rd        = hit && !wbs.wbs_we_i;
    // START and W1C bits live in byte lane 0, so those writes need sel[0].
    assign ctrl_wr   = wr && (reg_idx == 2'd0) && wbs.wbs_sel_i[0];
    assign n_wr      = wr && (reg_idx == 2'd1);
    assign status_wr = wr && (reg_idx == 2'd2) && wbs.wbs_sel_i[0];

    assign start_req   = ctrl_wr && wbs.wbs_dat_i[0] && (state == ST_IDLE);
    assign timeout_evt = (state == ST_START) && !core_b_i && (start_cnt == START_LAST);
    assign capture     = (state == ST_CAPTURE);
    assign unused_bits = ^{wbs.wbs_adr_i[1:0], wbs.wbs_dat_i[31:16], wbs.wbs_sel_i[3:2]};

    // State register; the start counter restarts every time START is entered.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state     <= ST_IDLE;
            start_cnt <= '0;
        end else begin
            state     <= state_nxt;
            start_cnt <= (state == ST_START) ? start_cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        unique case (state)
            ST_IDLE:    if (start_req) state_nxt = ST_START;
            ST_START:   if (core_b_i) state_nxt = ST_RUN;
                        else if (timeout_evt) state_nxt = ST_IDLE;
            ST_RUN:     if (!core_b_i) state_nxt = ST_CAPTURE;
            ST_CAPTURE: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        core_start_o = (state == ST_START);
        busy         = (state != ST_IDLE);
    end

    always_comb begin
        rdata = '0;
        unique case (reg_idx)
            2'd0: rdata = {30'd0, irq_en, 1'b0};
            2'd1: rdata = {16'd0, core_n_o};
            2'd2: rdata = {28'd0, core_b_i, timeout, done, busy};
            2'd3: rdata = result;
            default: rdata = '0;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every read sees pre-edge values.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            wbs.wbs_ack_o <= 1'b0;
            wbs.wbs_dat_o <= '0;
            irq_en        <= 1'b0;
            core_n_o      <= '0;
            done          <= 1'b0;
            timeout       <= 1'b0;
            result        <= '0;
            irq_o         <= 1'b0;
        end else begin
            wbs.wbs_ack_o <= hit;
            wbs.wbs_dat_o <= rd ? rdata : 32'd0;

            if (ctrl_wr) irq_en <= wbs.wbs_dat_i[1];
            if (n_wr && wbs.wbs_sel_i[0]) core_n_o[7:0]  <= wbs.wbs_dat_i[7:0];
            if (n_wr && wbs.wbs_sel_i[1]) core_n_o[15:8] <= wbs.wbs_dat_i[15:8];

            // Hardware set beats a software clear landing on the same edge.
            if (capture)                              done <= 1'b1;
            else if (status_wr && wbs.wbs_dat_i[1])   done <= 1'b0;
            if (timeout_evt)                          timeout <= 1'b1;
            else if (status_wr && wbs.wbs_dat_i[2])   timeout <= 1'b0;

            if (capture) result <= core_x_i;
            irq_o <= irq_en & done;
        end
    end

endmodule

// File: tb/tb_suma_mult_wb_slave.sv
// Directed + randomized bench for suma_mult_wb_slave with a behavioural core
// model and a register-level expectation model kept in bench variables.
module tb_suma_mult_wb_slave;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] A_CTRL = BASE + 32'h0;
    localparam logic [31:0] A_N    = BASE + 32'h4;
    localparam logic [31:0] A_STAT = BASE + 32'h8;
    localparam logic [31:0] A_RES  = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        core_start_o;
    logic [15:0] core_n_o;
    logic [31:0] core_x_i = '0;
    logic        core_b_i = 1'b0;
    logic        irq_o;

    int tests = 0;
    int fails = 0;

    // Core model knobs (written by the main sequence only).
    logic        core_auto = 1'b0;
    int          busy_len = 10;
    logic [31:0] next_x = '0;

    // Core model state and start-pulse monitor (written by their own process only).
    int start_seen = 0;
    int busy_left = 0;
    int start_hi = 0;
    int start_pulses = 0;
    logic start_prev = 1'b0;

    // Register model.
    logic [15:0] m_n = '0;
    logic [31:0] m_result = '0;

    suma_mult_wb_if bus ();

    suma_mult_wb_slave #(.BASE_ADDR(BASE), .START_TIMEOUT(16)) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst_n),
        .wbs          (bus),
        .core_start_o (core_start_o),
        .core_n_o     (core_n_o),
        .core_x_i     (core_x_i),
        .core_b_i     (core_b_i),
        .irq_o        (irq_o)
    );

    always #5 clk = ~clk;

    // Core: raise busy on the second cycle it sees start, hold busy_len cycles, then present X.
    always @(negedge clk) begin
        if (core_auto) begin
            if (core_b_i) begin
                if (busy_left <= 1) begin
                    core_b_i <= 1'b0;
                    core_x_i <= next_x;
                end else begin
                    busy_left <= busy_left - 1;
                end
            end else if (core_start_o) begin
                if (start_seen == 1) begin
                    core_b_i   <= 1'b1;
                    busy_left  <= busy_len;
                    start_seen <= 0;
                end else begin
                    start_seen <= start_seen + 1;
                end
            end else begin
                start_seen <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (core_start_o) start_hi <= start_hi + 1;
        if (core_start_o && !start_prev) start_pulses <= start_pulses + 1;
        start_prev <= core_start_o;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Call #1 after a rising edge; the hit lands on the next rising edge.
    task automatic bus_raw(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rdata);
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_adr_i = adr;
        bus.wbs_dat_i = dat;
        bus.wbs_sel_i = sel;
        @(negedge clk);
        check("ack_before_hit", {31'd0, bus.wbs_ack_o}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("ack_after_hit", {31'd0, bus.wbs_ack_o}, 32'd1);
        rdata = bus.wbs_dat_o;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        @(negedge clk);
        check("ack_drops", {bus.wbs_ack_o, bus.wbs_dat_o[30:0]}, 32'd0);
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] dummy;
        @(posedge clk); #1;
        bus_raw(1'b1, adr, dat, sel, dummy);
    endtask

    task automatic wb_read(input logic [31:0] adr, output logic [31:0] dat);
        @(posedge clk); #1;
        bus_raw(1'b0, adr, $urandom, 4'($urandom), dat);
    endtask

    task automatic read_check(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0] d;
        wb_read(adr, d);
        check(tag, d, exp);
    endtask

    task automatic wait_core_b(input logic level, input string tag);
        int i = 0;
        while (core_b_i !== level && i < 100) begin
            @(posedge clk);
            i++;
        end
        check(tag, {31'd0, core_b_i}, {31'd0, level});
    endtask

    initial begin
        logic [31:0] d, wd;
        logic [3:0]  ws;
        int          p0, p1, h0, i;
        bit          seen;

        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
        bus.wbs_sel_i = '0;   bus.wbs_adr_i = '0;   bus.wbs_dat_i = '0;

        // Reset with random bus activity: nothing acknowledged, all outputs 0.
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            bus.wbs_cyc_i = 1'($urandom); bus.wbs_stb_i = 1'($urandom);
            bus.wbs_we_i  = 1'($urandom); bus.wbs_sel_i = 4'($urandom);
            bus.wbs_adr_i = BASE + 32'($urandom_range(0, 15));
            bus.wbs_dat_i = $urandom;
            @(negedge clk);
            check("reset_outputs", {bus.wbs_ack_o, core_start_o, irq_o, core_n_o, 13'd0},
                  32'd0);
            check("reset_dat_o", bus.wbs_dat_o, 32'd0);
        end
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        read_check("status_after_reset", A_STAT, 32'h0);
        read_check("result_after_reset", A_RES, 32'h0);

        // Byte-lane N writes.
        wb_write(A_N, 32'h0000_ABCD, 4'b0001);
        read_check("n_sel0", A_N, 32'h0000_00CD);
        wb_write(A_N, 32'h0000_ABCD, 4'b0011);
        read_check("n_sel01", A_N, 32'h0000_ABCD);
        m_n = 16'hABCD;
        for (int k = 0; k < 8; k++) begin
            wd = $urandom;
            ws = 4'($urandom);
            wb_write(A_N, wd, ws);
            if (ws[0]) m_n[7:0]  = wd[7:0];
            if (ws[1]) m_n[15:8] = wd[15:8];
            read_check("n_random", A_N, {16'd0, m_n});
            check("core_n_random", {16'd0, core_n_o}, {16'd0, m_n});
        end
        read_check("n_adr_low_ignored", BASE + 32'h6, {16'd0, m_n});

        // Out-of-window access is never acknowledged.
        @(posedge clk); #1;
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
        bus.wbs_adr_i = BASE + 32'h10;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.wbs_ack_o) seen = 1'b1;
        end
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
        check("miss_no_ack", {31'd0, seen}, 32'd0);

        // Full operation.
        core_auto = 1'b1;
        busy_len  = 10;
        next_x    = 32'h0000_0078;
        wb_write(A_CTRL, 32'h2, 4'b0001);
        read_check("ctrl_irq_en", A_CTRL, 32'h2);
        wb_write(A_N, 32'd5, 4'b1111);
        m_n = 16'd5;
        check("core_n_5", {16'd0, core_n_o}, 32'd5);
        p0 = start_pulses;
        h0 = start_hi;
        wb_write(A_CTRL, 32'h3, 4'b0001);
        check("start_latency", {31'd0, core_start_o}, 32'd1);
        wait_core_b(1'b1, "core_busy_rise");
        read_check("status_running", A_STAT, 32'h9);
        p1 = start_pulses;
        wb_write(A_CTRL, 32'h3, 4'b0001);
        check("no_restart_while_busy", {31'd0, core_start_o}, 32'd0);
        wait_core_b(1'b0, "core_busy_fall");
        repeat (2) @(posedge clk);
        m_result = 32'h78;
        read_check("result_78", A_RES, m_result);
        read_check("status_done", A_STAT, 32'h2);
        check("irq_on_done", {31'd0, irq_o}, 32'd1);
        check("start_high_cycles", 32'(start_hi - h0), 32'd2);
        check("start_single_pulse", 32'(start_pulses - p0), 32'd1);
        check("start_ignored_busy", 32'(start_pulses - p1), 32'd0);
        wb_write(A_RES, $urandom, 4'b1111);
        read_check("result_write_ignored", A_RES, m_result);
        wb_write(A_STAT, 32'h2, 4'b0001);
        check("irq_cleared", {31'd0, irq_o}, 32'd0);
        read_check("status_cleared", A_STAT, 32'h0);

        // DONE W1C landing on the capture edge: set wins.
        next_x = $urandom;
        wb_write(A_CTRL, 32'h3, 4'b0001);
        wait_core_b(1'b1, "op2_busy_rise");
        wait_core_b(1'b0, "op2_busy_fall");
        #1 bus_raw(1'b1, A_STAT, 32'h2, 4'b0001, d);
        read_check("done_set_wins", A_STAT, 32'h2);
        m_result = next_x;
        read_check("result_op2", A_RES, m_result);
        check("irq_op2", {31'd0, irq_o}, 32'd1);

        // Disabled byte lanes suppress W1C and START.
        wb_write(A_STAT, 32'h6, 4'b0000);
        read_check("w1c_sel_clear", A_STAT, 32'h2);
        wb_write(A_STAT, 32'h2, 4'b0001);
        p0 = start_pulses;
        wb_write(A_CTRL, 32'h3, 4'b1110);
        repeat (3) @(posedge clk);
        check("start_sel_clear", 32'(start_pulses - p0), 32'd0);
        read_check("ctrl_kept", A_CTRL, 32'h2);

        // RESULT read in the capture cycle returns the previous value.
        next_x = $urandom;
        wb_write(A_CTRL, 32'h3, 4'b0001);
        wait_core_b(1'b1, "op3_busy_rise");
        wait_core_b(1'b0, "op3_busy_fall");
        #1 bus_raw(1'b0, A_RES, 32'h0, 4'b1111, d);
        check("result_old_in_capture", d, m_result);
        m_result = next_x;
        read_check("result_new", A_RES, m_result);
        wb_write(A_STAT, 32'h2, 4'b0001);

        // Start timeout with a silent core.
        core_auto = 1'b0;
        p0 = start_pulses;
        h0 = start_hi;
        wb_write(A_CTRL, 32'h3, 4'b0001);
        i = 0;
        while (core_start_o && i < 60) begin
            @(posedge clk);
            i++;
        end
        @(negedge clk);
        check("timeout_high_cycles", 32'(start_hi - h0), 32'd16);
        check("timeout_one_pulse", 32'(start_pulses - p0), 32'd1);
        read_check("status_timeout", A_STAT, 32'h4);
        check("irq_not_on_timeout", {31'd0, irq_o}, 32'd0);
        wb_write(A_STAT, 32'h4, 4'b0001);
        read_check("timeout_cleared", A_STAT, 32'h0);

        // Reset while the core is running.
        core_auto = 1'b1;
        busy_len  = 30;
        next_x    = $urandom;
        wb_write(A_CTRL, 32'h3, 4'b0001);
        wait_core_b(1'b1, "op4_busy_rise");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrun_reset_outputs",
              {bus.wbs_ack_o, core_start_o, irq_o, core_n_o, 13'd0}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        m_n = '0;
        m_result = '0;
        wait_core_b(1'b0, "op4_busy_fall");
        repeat (3) @(posedge clk);
        read_check("midrun_status", A_STAT, 32'h0);
        read_check("midrun_result", A_RES, m_result);
        read_check("midrun_n", A_N, {16'd0, m_n});
        read_check("midrun_ctrl", A_CTRL, 32'h0);
        check("midrun_irq", {31'd0, irq_o}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
